// File: rtl/hamming_decoder_7_4_pipe.sv
// Two-stage pipelined Hamming(7,4) single-error-correcting decoder.
// Stage 1 captures the received word with its syndrome; stage 2 holds the
// corrected word. A ready/valid handshake on both sides provides full
// throughput and backpressure. A saturating counter tallies delivered words
// that needed correction.
module hamming_decoder_7_4_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_codeword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [6:0]       out_codeword,
  output logic [2:0]       out_syndrome,
  output logic             out_corrected,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_count
);

  // Syndrome {s4,s2,s1}: the 1-based position of a single flipped bit.
  function automatic logic [2:0] calc_syndrome(input logic [6:0] cw);
    logic s1, s2, s4;
    s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return {s4, s2, s1};
  endfunction

  // Flip the bit the syndrome points at; a zero syndrome leaves the word alone.
  function automatic logic [6:0] correct_word(input logic [6:0] cw, input logic [2:0] syn);
    logic [6:0] mask;
    mask = 7'd0;
    if (syn != 3'd0) mask = 7'b000_0001 << (syn - 3'd1);
    return cw ^ mask;
  endfunction

  logic             vld_p1_q, vld_p2_q;
  logic [6:0]       cw_p1_q, cw_p2_q, cw_p2_d;
  logic [2:0]       syn_p1_q, syn_p2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s2_can_load;
  logic             out_hs_corr;

  assign s2_can_load = !vld_p2_q || out_ready;
  assign in_ready    = !vld_p1_q || s2_can_load;

  // Stage-valid flags advance whenever the stage ahead can take a word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (in_ready)    vld_p1_q <= in_valid;
      if (s2_can_load) vld_p2_q <= vld_p1_q;
    end
  end

  // ---- stage 1: received word and its syndrome ----
  // Capture the accepted input word and its syndrome.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      cw_p1_q  <= in_codeword;
      syn_p1_q <= calc_syndrome(in_codeword);
    end
  end

  assign cw_p2_d = correct_word(cw_p1_q, syn_p1_q);

  // ---- stage 2: corrected word ----
  // Load the corrected result; it is held while downstream stalls.
  always_ff @(posedge clk) begin
    if (s2_can_load && vld_p1_q) begin
      cw_p2_q  <= cw_p2_d;
      syn_p2_q <= syn_p1_q;
    end
  end

  // Payload registers carry no reset, so fields are forced to zero when idle.
  assign out_valid     = vld_p2_q;
  assign out_codeword  = vld_p2_q ? cw_p2_q : 7'd0;
  assign out_data      = vld_p2_q ? {cw_p2_q[6], cw_p2_q[5], cw_p2_q[4], cw_p2_q[2]} : 4'd0;
  assign out_syndrome  = vld_p2_q ? syn_p2_q : 3'd0;
  assign out_corrected = vld_p2_q && (syn_p2_q != 3'd0);

  assign out_hs_corr = out_valid && out_ready && out_corrected;

  // Next count: clear wins, otherwise saturating increment on corrected delivery.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                           cnt_d = '0;
    else if (out_hs_corr && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Corrected-word counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;

endmodule

// File: tb/tb_hamming_decoder_7_4_pipe.sv
// Directed bench for hamming_decoder_7_4_pipe: an encoder-based reference
// builds expected outputs, a negedge monitor scoreboards every handshake,
// and directed sequences exercise latency, backpressure, counter saturation
// and clear, and mid-flight reset. A 4-bit-counter instance shares stimulus.
module tb_hamming_decoder_7_4_pipe;

  typedef struct packed {
    logic [3:0] d;
    logic [6:0] cw;
    logic [2:0] s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_codeword = 7'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_data;
  logic [6:0]  out_codeword;
  logic [2:0]  out_syndrome;
  logic        out_corrected;
  logic        cnt_clr = 1'b0;
  logic [15:0] err_count;

  logic        d4_in_ready, d4_out_valid, d4_out_corrected;
  logic [3:0]  d4_out_data;
  logic [6:0]  d4_out_codeword;
  logic [2:0]  d4_out_syndrome;
  logic [3:0]  d4_err_count;

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_out = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  int   exp_cnt4 = 0;
  bit   mon_en = 1'b0;
  exp_t cur;
  exp_t q[$];

  hamming_decoder_7_4_pipe #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_codeword(in_codeword), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_codeword(out_codeword), .out_syndrome(out_syndrome),
    .out_corrected(out_corrected), .cnt_clr(cnt_clr), .err_count(err_count)
  );

  hamming_decoder_7_4_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d4_in_ready),
    .in_codeword(in_codeword), .out_valid(d4_out_valid), .out_ready(out_ready),
    .out_data(d4_out_data), .out_codeword(d4_out_codeword), .out_syndrome(d4_out_syndrome),
    .out_corrected(d4_out_corrected), .cnt_clr(cnt_clr), .err_count(d4_err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Scoreboard: compare counters, pop on output handshake, push on input handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("err_count", 32'(err_count), 32'(exp_cnt));
      chk("err_count_w4", 32'(d4_err_count), 32'(exp_cnt4));
      if (!rst_n) begin
        q.delete();
        exp_cnt  = 0;
        exp_cnt4 = 0;
      end else begin
        logic hs_corr;
        exp_t e;
        hs_corr = 1'b0;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            n_out++;
            chk("out_data", 32'(out_data), 32'(e.d));
            chk("out_codeword", 32'(out_codeword), 32'(e.cw));
            chk("out_syndrome", 32'(out_syndrome), 32'(e.s));
            chk("out_corrected", 32'(out_corrected), 32'(e.s != 3'd0));
            hs_corr = (e.s != 3'd0);
          end
        end
        if (cnt_clr) begin
          exp_cnt  = 0;
          exp_cnt4 = 0;
        end else if (hs_corr) begin
          if (exp_cnt < 65535) exp_cnt++;
          if (exp_cnt4 < 15) exp_cnt4++;
        end
        if (in_valid && in_ready) q.push_back(cur);
      end
    end
  end

  // Offer one word (with flip position e: 0 = none, 1..7 = bit e-1) until accepted.
  task automatic send(input logic [3:0] d, input int e);
    logic [6:0] clean;
    int n;
    clean = enc(d);
    cur.d  = d;
    cur.cw = clean;
    cur.s  = 3'(e);
    in_valid = 1'b1;
    in_codeword = (e == 0) ? clean : (clean ^ (7'd1 << (e - 1)));
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
    end
    chk("drain", 32'(q.size() == 0 && !out_valid), 32'd1);
  endtask

  initial begin
    int c0;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_codeword", 32'(out_codeword), 32'd0);
    chk("rst_out_syndrome", 32'(out_syndrome), 32'd0);
    chk("rst_out_corrected", 32'(out_corrected), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    mon_en = 1'b1;

    // clean 7'h55, two-cycle latency
    @(posedge clk); #1;
    send(4'hB, 0);
    chk("t33_in_cw", 32'(in_codeword), 32'h55);
    @(negedge clk);
    chk("t33_lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t33_out_valid", 32'(out_valid), 32'd1);
    chk("t33_out_data", 32'(out_data), 32'hB);
    chk("t33_out_syndrome", 32'(out_syndrome), 32'd0);
    chk("t33_out_corrected", 32'(out_corrected), 32'd0);
    @(negedge clk);
    chk("t33_err_count", 32'(err_count), 32'd0);
    drain();

    // 7'h45: bit 4 flipped
    @(posedge clk); #1;
    send(4'hB, 5);
    chk("t34_in_cw", 32'(in_codeword), 32'h45);
    @(negedge clk);
    @(negedge clk);
    chk("t34_out_valid", 32'(out_valid), 32'd1);
    chk("t34_out_codeword", 32'(out_codeword), 32'h55);
    chk("t34_out_data", 32'(out_data), 32'hB);
    chk("t34_out_syndrome", 32'(out_syndrome), 32'd5);
    chk("t34_out_corrected", 32'(out_corrected), 32'd1);
    @(negedge clk);
    chk("t34_err_count", 32'(err_count), 32'd1);
    drain();

    // 16 data x 8 error patterns, back-to-back
    @(posedge clk); #1;
    c0 = cyc;
    for (int d = 0; d < 16; d++)
      for (int e = 0; e < 8; e++)
        send(4'(d), e);
    chk("t35_cycles", 32'(cyc - c0), 32'd128);
    drain();
    chk("t35_outputs", 32'(n_out), 32'd130);
    chk("t35_err_count", 32'(err_count), 32'd113);
    chk("t35_err_count_w4", 32'(d4_err_count), 32'hF);

    // backpressure: out_ready low, three words offered
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'h1, 1);
    send(4'h2, 0);
    cur.d = 4'h3; cur.cw = enc(4'h3); cur.s = 3'd7;
    in_valid = 1'b1;
    in_codeword = enc(4'h3) ^ 7'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t36_in_ready_low", 32'(in_ready), 32'd0);
      chk("t36_hold_valid", 32'(out_valid), 32'd1);
      chk("t36_hold_codeword", 32'(out_codeword), 32'(enc(4'h1)));
      chk("t36_hold_data", 32'(out_data), 32'h1);
      chk("t36_hold_syndrome", 32'(out_syndrome), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'h3, 7);
    drain();
    chk("t36_outputs", 32'(n_out), 32'd133);
    chk("t36_err_count", 32'(err_count), 32'd115);

    // clear coincides with a corrected handshake
    @(posedge clk); #1;
    send(4'h4, 4);
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(negedge clk);
    chk("t37_hs_corrected", 32'(out_valid && out_corrected), 32'd1);
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("t37_err_count", 32'(err_count), 32'd0);
    chk("t37_err_count_w4", 32'(d4_err_count), 32'd0);
    drain();

    // reset with two words in flight
    @(posedge clk); #1;
    send(4'h5, 2);
    send(4'h6, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t38_out_valid", 32'(out_valid), 32'd0);
    chk("t38_out_data", 32'(out_data), 32'd0);
    chk("t38_out_codeword", 32'(out_codeword), 32'd0);
    chk("t38_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t38_in_ready", 32'(in_ready), 32'd1);
    chk("t38_no_stale_0", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t38_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(4'h9, 0);
    drain();
    chk("t38_outputs", 32'(n_out), 32'd135);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
